scan_chain_loader: RTL
======================

# scan_chain_loader

Configuration writer for the fabric scan chain. Accepts a byte stream of configuration data from the host-side port, serialises it onto the chain's serial input with the chain clock-enable, then recirculates the whole chain once to read it back and checks it against a CRC of what was loaded. Sits between the configuration interface and the first connection block or logic block in the chain; the chain's final serial output returns to this block.

## Interface

- CHAIN_LEN, 64: number of configuration flops in the chain, minimum 1.
- CNT_W, $clog2(CHAIN_LEN+1): width of the bit counter.
- CLK  in  1  chain and block clock; all state changes on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- START  in  1  one-cycle request to begin a load; sampled only in IDLE.
- DIN  in  8  configuration byte, LSB shifted first.
- DIN_VALID  in  1  DIN holds a valid byte.
- DIN_READY  out  1  block accepts DIN this cycle.
- CHAIN_SOUT  in  1  serial output of the last chain element.
- CHAIN_SIN  out  1  serial input to the first chain element.
- CHAIN_CE  out  1  chain shift enable.
- BUSY  out  1  high in LOAD and VERIFY.
- DONE  out  1  one-cycle pulse when verification completes.
- ERROR  out  1  readback CRC mismatch; held until the next accepted START.

## Operation

- States: IDLE, LOAD, VERIFY, FINISH.
- IDLE: START -> LOAD. Clear the bit counter, the byte buffer, ERROR, crc_in and crc_out (both 0xFFFF).
- LOAD: an 8-bit shift buffer with a 4-bit fill count. DIN_READY = (fill == 0). A byte is accepted on DIN_VALID & DIN_READY and sets fill to 8.
  - When fill > 0: CHAIN_CE = 1, CHAIN_SIN = buffer[0], update crc_in with that bit, shift the buffer right, decrement fill, and increment the bit counter.
  - When fill == 0: CHAIN_CE = 0, so the chain holds (host stall).
  - When the bit counter reaches CHAIN_LEN -> VERIFY. Any bits left in the buffer are discarded. The host sends exactly ceil(CHAIN_LEN/8) bytes.
- VERIFY: CHAIN_CE = 1 for exactly CHAIN_LEN cycles. CHAIN_SIN = CHAIN_SOUT through a combinational mux, so the chain ends with unchanged contents. Update crc_out with CHAIN_SOUT each cycle. When the count completes -> FINISH.
- FINISH: DONE = 1 for one cycle. ERROR <= (crc_out != crc_in). Then -> IDLE.
- CRC: CRC-16-CCITT, polynomial 0x1021, init 0xFFFF, bitwise, no reflection, no final XOR.
- Bit order: the first bit loaded ends in the chain position farthest from CHAIN_SIN and is the first bit out during VERIFY.
- START outside IDLE is ignored. DIN_READY = 0 outside LOAD.

## Timing

- Reset values: CHAIN_CE 0, CHAIN_SIN 0, DIN_READY 0, BUSY 0, DONE 0, ERROR 0; state IDLE.
- Reset mid-operation: CHAIN_CE drops asynchronously. Chain contents are undefined and a new load is required.
- CHAIN_CE, BUSY, DONE and DIN_READY are registered.
- CHAIN_SIN is registered in LOAD and combinational from CHAIN_SOUT in VERIFY.
- The chain captures CHAIN_SIN on the rising edge where CHAIN_CE = 1. CHAIN_SOUT is sampled on the same edge.
- Byte accepted at edge N: bit 0 is driven in cycle N+1, and the next DIN_READY is in cycle N+8.
- Back-to-back bytes give one bit per cycle except for 1 bubble cycle per byte.
- Total latency with no stalls: LOAD about 9·ceil(CHAIN_LEN/8) cycles, then CHAIN_LEN VERIFY cycles, then the DONE cycle.
- START held high in FINISH or IDLE on the DONE cycle is ignored; a new START is taken only after the block has returned to IDLE.

## Structure

- Shared package scan_pkg holds:
  - state enum {IDLE, LOAD, VERIFY, FINISH};
  - CRC_POLY = 16'h1021 and CRC_INIT = 16'hFFFF;
  - function crc16_bit(crc, bit).
- One natural sub-module: scan_crc16, a 16-bit serial CRC register with clear and enable. Instantiate it twice, once for the input side and once for the readback side.

## Test plan

- CHAIN_LEN=16 shift-register model; bytes 0xA5, 0x3C with no stalls -> exactly 16 CE-high LOAD cycles, model content 0x3CA5 (bit 0 farthest), DONE after 16 VERIFY cycles, ERROR=0.
- DIN_VALID low for 5 cycles between bytes -> CE low for those cycles, final model content unchanged, ERROR=0.
- CHAIN_LEN=13, bytes 0xFF, 0x1F -> 13 shifts, upper 3 bits of byte 2 discarded, ERROR=0.
- Model flips one bit during VERIFY -> DONE pulses, ERROR=1 and stays high until the next START.
- RST_N low during LOAD after 5 bits -> CHAIN_CE drops immediately, outputs at reset values; a following full load is correct.
- START pulsed during LOAD and VERIFY -> ignored; the bit count is still exactly CHAIN_LEN per phase.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared types and CRC helper for the scan chain loader.
// FSM state enum, CRC-16-CCITT constants and a one-bit CRC step.
package scan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    VERIFY,
    FINISH
  } state_t;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // MSB-first serial CRC step, no reflection.
  function automatic logic [15:0] crc16_bit(
    input logic [15:0] crc,
    input logic        b
  );
    logic fb;
    fb = crc[15] ^ b;
    return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/scan_crc16.sv
// Serial CRC-16-CCITT register with synchronous clear and bit enable.
// Ports: clk, rst_n, clr, en, din (serial bit) -> crc (16-bit value).
module scan_crc16
  import scan_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= CRC_INIT;
    end else if (clr) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= crc16_bit(crc, din);
    end
  end

endmodule

// File: rtl/scan_chain_loader.sv
// Serialises host config bytes into the fabric scan chain, then recirculates it once and CRC-checks the readback.
// Ports: start/din/din_valid/din_ready host side; chain_sin/chain_ce/chain_sout chain side; busy/done/error status.
module scan_chain_loader
  import scan_pkg::*;
#(
  parameter int CHAIN_LEN = 64,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  input  logic       chain_sout,
  output logic       chain_sin,
  output logic       chain_ce,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam logic [CNT_W-1:0] LEN  = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       buf_q, buf_d;
  logic [3:0]       fill_q, fill_d;
  logic             ce_q, ce_d;
  logic             sin_q, sin_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic             err_q, err_d;
  logic             crc_clr;
  logic             in_en;
  logic             out_en;
  logic [15:0]      crc_in;
  logic [15:0]      crc_out;

  scan_crc16 u_crc_in (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (crc_clr),
    .en    (in_en),
    .din   (buf_q[0]),
    .crc   (crc_in)
  );

  scan_crc16 u_crc_out (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (crc_clr),
    .en    (out_en),
    .din   (chain_sout),
    .crc   (crc_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      fill_q  <= '0;
      ce_q    <= 1'b0;
      sin_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      fill_q  <= fill_d;
      ce_q    <= ce_d;
      sin_q   <= sin_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    fill_d  = fill_q;
    ce_d    = 1'b0;
    sin_d   = sin_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    ready_d = 1'b0;
    err_d   = err_q;
    crc_clr = 1'b0;
    in_en   = 1'b0;
    out_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
          buf_d   = '0;
          fill_d  = '0;
          sin_d   = 1'b0;
          err_d   = 1'b0;
          crc_clr = 1'b1;
          busy_d  = 1'b1;
          ready_d = 1'b1;
        end
      end
      LOAD: begin
        busy_d = 1'b1;
        if (cnt_q == LEN) begin
          // last bit is captured by the chain on this edge;
          // leftover buffer bits are dropped
          state_d = VERIFY;
          cnt_d   = '0;
          fill_d  = '0;
          sin_d   = 1'b0;
          ce_d    = 1'b1;
        end else begin
          if (fill_q != 4'd0) begin
            ce_d   = 1'b1;
            sin_d  = buf_q[0];
            in_en  = 1'b1;
            buf_d  = {1'b0, buf_q[7:1]};
            fill_d = fill_q - 4'd1;
            cnt_d  = cnt_q + 1'b1;
          end else if (din_valid && ready_q) begin
            buf_d  = din;
            fill_d = 4'd8;
          end
          ready_d = (fill_d == 4'd0) && (cnt_d != LEN);
        end
      end
      VERIFY: begin
        busy_d = 1'b1;
        ce_d   = 1'b1;
        out_en = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          // fold in the final readback bit so ERROR lines up with DONE
          state_d = FINISH;
          ce_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          err_d   = crc16_bit(crc_out, chain_sout) != crc_in;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign chain_sin = (state_q == VERIFY) ? chain_sout : sin_q;
  assign chain_ce  = ce_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign din_ready = ready_q;
  assign error     = err_q;

endmodule
